adder_mul_ctrl: RTL

Iterative shift-and-add multiply sequencer that time-shares the core's parallel-prefix adder (group generate/propagate tree). It accepts one multiply request, drives the external adder's operands for WIDTH cycles, and returns the 2*WIDTH-bit product over a valid/ready handshake. It sits in the execute stage next to the ALU and owns the adder operand muxing while busy.

---
 rtl/adder_mul_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/adder_mul_ctrl.sv
// adder_mul_ctrl: iterative shift-and-add multiply sequencer that borrows the
// core's parallel-prefix adder for WIDTH cycles per request and returns the
// full 2*WIDTH-bit product over a valid/ready handshake.
// Optional feature macro: MUL_SIGNED_EN adds the in_signed port and
// two's-complement multiplication. The default build is unsigned only.

`ifndef INPUTSIZE
`define INPUTSIZE 32
`endif

module adder_mul_ctrl #(
    parameter int WIDTH = `INPUTSIZE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_mcand,
    input  logic [WIDTH-1:0]   in_mplier,
`ifdef MUL_SIGNED_EN
    input  logic               in_signed,
`endif
    input  logic               flush,
    output logic [WIDTH-1:0]   adder_a,
    output logic [WIDTH-1:0]   adder_b,
    output logic               adder_cin,
    input  logic [WIDTH-1:0]   adder_sum,
    input  logic               adder_cout,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_prod,
    output logic               busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   hi, lo, mcand;
    logic [CNT_W-1:0]   cnt;
    logic               sgn;
    logic               ext;
    logic               accept;
    logic               last;

    // A request is only taken in IDLE and never in a flush cycle.
    assign accept = in_valid && (state == IDLE) && !flush;
    assign last   = (cnt == CNT_LAST);

    // State register.
    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; flush wins over every other transition.
    // NOTE: each combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept)    state_nxt = CALC;
            CALC:    if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
        if (flush) begin
            state_nxt = IDLE;
        end
    end

    // Handshake, status and adder operand outputs; operands idle at 0 outside CALC.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state == CALC) || (state == DONE);
        out_prod  = '0;
        adder_a   = '0;
        adder_b   = '0;
        adder_cin = 1'b0;
        ext       = adder_cout;
        if (state == DONE) begin
            out_prod = {hi, lo};
        end
        if (state == CALC) begin
            adder_a = hi;
            adder_b = lo[0] ? mcand : '0;
`ifdef MUL_SIGNED_EN
            // The multiplier's sign bit carries weight -2^(WIDTH-1), so the
            // last partial product is subtracted instead of added.
            if (sgn && last && lo[0]) begin
                adder_b   = ~mcand;
                adder_cin = 1'b1;
            end
            // Signed partial sums need the true sign of the WIDTH+1-bit result.
            if (sgn) begin
                ext = adder_a[WIDTH-1] ^ adder_b[WIDTH-1] ^ adder_cout;
            end
`endif
        end
    end

    // Datapath: load on acceptance, then shift the accumulated sum right each CALC cycle.
    // NOTE: every datapath register is cleared by the synchronous reset so the
    // product output and operand muxes come up at a defined zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi    <= '0;
            lo    <= '0;
            mcand <= '0;
            cnt   <= '0;
        end else if (accept) begin
            hi    <= '0;
            lo    <= in_mplier;
            mcand <= in_mcand;
            cnt   <= '0;
        end else if (state == CALC) begin
            hi <= {ext, adder_sum[WIDTH-1:1]};
            lo <= {adder_sum[0], lo[WIDTH-1:1]};
            if (!last) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef MUL_SIGNED_EN
    // Signedness of the request in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            sgn <= 1'b0;
        end else if (accept) begin
            sgn <= in_signed;
        end
    end
`else
    assign sgn = 1'b0;
`endif

endmodule
